param_stream_mux: RTL and testbench
===================================

// Module: param_stream_mux
// PURPOSE
//  Parametrised N-to-1 packet stream multiplexer: generalises the plain 4-to-1 select mux to NUM_CH
//  channels of DATA_W bits with valid/ready handshake, packet locking on 'last', and manual or
//  round-robin channel selection. Registered output stage. Sits between multiple stream producers
//  and one shared consumer (e.g. UART/TX path, shared bus port).
// PARAMETERS
//  NUM_CH   4                    number of input channels (>=2, need not be a power of two)
//  DATA_W   8                    data width per channel
//  SEL_W    $clog2(NUM_CH)       channel index width (derived; do not override)
// PORTS
//  clk        in   1               clock; all logic on rising edge
//  rst        in   1               reset, asynchronous, active-high
//  mode       in   1               0 = manual (use sel), 1 = round-robin
//  sel        in   SEL_W           manual channel index (mode=0)
//  in_data    in   NUM_CH*DATA_W   channel c at [c*DATA_W +: DATA_W]
//  in_valid   in   NUM_CH          per-channel beat valid
//  in_last    in   NUM_CH          per-channel end-of-packet marker
//  in_ready   out  NUM_CH          per-channel accept
//  out_data   out  DATA_W          registered output data
//  out_valid  out  1               registered output valid
//  out_last   out  1               registered end-of-packet
//  out_ready  in   1               consumer accept
//  grant      out  SEL_W           currently/last granted channel
//  busy       out  1               1 while in LOCKED
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, out_last=0, grant=0, busy=0, in_ready=0, state=IDLE,
//   rr pointer=NUM_CH-1 (ch0 highest priority first). Reset mid-packet drops the packet; no flush.
//  FSM IDLE: mode/sel sampled only here. Manual: if sel<NUM_CH and in_valid[sel] -> grant<=sel,
//   go LOCKED. sel>=NUM_CH -> no grant, stay IDLE. RR: pick first c with in_valid[c], searching
//   ptr+1, ptr+2, ... wrapping at NUM_CH-1 -> 0; grant<=c, ptr<=c, go LOCKED. None valid -> stay.
//   Arbitration costs exactly one IDLE cycle; in_ready is all-zero in IDLE.
//  FSM LOCKED: busy=1; only in_ready[grant] may be 1; in_ready[grant] = !out_valid | out_ready.
//   Changes to sel/mode/other valids ignored until packet ends.
//   Beat accepted (in_valid[grant] & in_ready[grant]) with in_last[grant]=1 -> IDLE next cycle.
//  Output register: on accept, out_data/out_last <= channel beat, out_valid<=1 (latency 1 cycle).
//   out_valid & out_ready & no accept -> out_valid<=0. Accept and drain same cycle -> out_valid
//   stays 1, new beat replaces old: 1 beat/cycle sustained throughput. out_valid=1 & out_ready=0
//   -> out_* hold stable, in_ready=0 (no loss, no duplication).
//  Last beat may still sit in out register while FSM is back in IDLE; next packet's first beat
//   is admitted only when register drains or drains same cycle.
//  Packet-to-packet gap: minimum one cycle (IDLE) on the input side.
//  Single-beat packet (last on first beat) is legal: IDLE->LOCKED->IDLE.
// STRUCTURE
//  Package param_stream_mux_pkg: state enum {ST_IDLE, ST_LOCKED}; mode constants MODE_MANUAL=1'b0,
//   MODE_RR=1'b1.
//  Sub-module rr_pick (combinational, params NUM_CH/SEL_W): inputs req[NUM_CH], ptr; outputs
//   found, idx = first set req after ptr with wrap. Data select is an indexed part-select.
// TESTING
//  1 Manual: mode=0, sel=2, ch2 sends 3 beats A1,A2,A3(last), out_ready=1 -> out A1..A3 on
//    consecutive cycles, first one 2 cycles after in_valid, out_last only with A3, grant=2.
//  2 RR fairness: NUM_CH=4, all channels valid, 1-beat packets -> grant sequence 0,1,2,3,0,...
//    after reset; then only ch1,ch3 valid -> 1,3,1,3.
//  3 Lock: ch0 granted mid 4-beat packet, set sel=3/mode=1 and raise ch3 valid -> ch0 beats
//    continue uninterrupted, in_ready[3]=0 until ch0 last accepted.
//  4 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, in_ready=0;
//    release -> no dropped or duplicated beats (compare against scoreboard).
//  5 Boundary: NUM_CH=3, mode=0, sel=3 -> no grant, busy=0; RR wrap from ch2 to ch0 verified.
//  6 Async reset asserted mid-packet (between clocks) -> outputs/in_ready 0 immediately; after
//    release ch0 has first RR priority.

Source files
------------

// File: rtl/param_stream_mux_pkg.sv
// Shared types and constants for the parametrised packet stream multiplexer.
package param_stream_mux_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/param_stream_mux_if.sv
// Stream bundle between the producers/consumer (master side) and the multiplexer (slave side).
interface param_stream_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
);

    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic [SEL_W-1:0]         grant;
    logic                     busy;

    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, grant, busy
    );

    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, grant, busy
    );

endinterface

// File: rtl/param_stream_mux_rr_pick.sv
// Combinational round-robin picker: first requesting channel after ptr, wrapping NUM_CH-1 -> 0.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    int               cand_i;
    logic [SEL_W-1:0] cand;

    // Candidates are visited ptr+1 .. ptr+NUM_CH, so ptr itself has lowest priority.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        cand_i = 0;
        cand   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_i = int'(ptr) + k;
            if (cand_i >= NUM_CH) begin
                cand_i = cand_i - NUM_CH;
            end
            cand = SEL_W'(cand_i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/param_stream_mux.sv
// N-to-1 packet stream multiplexer with packet locking, manual or round-robin selection
// and a registered output stage sustaining one beat per cycle.
module param_stream_mux
    import param_stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    param_stream_mux_if.slave bus
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] beat_data;
    logic              beat_valid;
    logic              beat_last;
    logic              can_take;
    logic              accept;
    logic              sel_ok;
    logic              rr_found;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_CH-1:0] in_ready_c;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign ch_data[c] = bus.in_data[c*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    assign beat_data  = ch_data[grant_q];
    assign beat_valid = bus.in_valid[grant_q];
    assign beat_last  = bus.in_last[grant_q];
    // A new beat fits when the output register is empty or is being drained this cycle.
    assign can_take   = !out_valid_q || bus.out_ready;
    assign accept     = (state_q == ST_LOCKED) && beat_valid && can_take;
    assign sel_ok     = int'(bus.sel) < NUM_CH;

    always_comb begin
        in_ready_c = '0;
        if (state_q == ST_LOCKED) begin
            in_ready_c[grant_q] = can_take;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.mode == MODE_RR) begin
                    if (rr_found) begin
                        grant_d = rr_idx;
                        ptr_d   = rr_idx;
                        state_d = ST_LOCKED;
                    end
                end else if (sel_ok && bus.in_valid[bus.sel]) begin
                    grant_d = bus.sel;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept && beat_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_data_d  = beat_data;
            out_last_d  = beat_last;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= SEL_W'(NUM_CH - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_param_stream_mux.sv
// Scoreboard bench for param_stream_mux: a 4-channel and a 3-channel instance driven by
// per-channel beat buffers, with output monitors popping hand-ordered expected beats.
module tb_param_stream_mux;
    import param_stream_mux_pkg::*;

    logic clk;
    logic rst;

    int err_count   = 0;
    int check_count = 0;

    logic [8:0] sbuf [2][4][64];
    int         head [2][4];
    int         tail [2][4];
    logic [8:0] exp_q4 [$];
    logic [8:0] exp_q3 [$];

    param_stream_mux_if #(.NUM_CH(4), .DATA_W(8)) bus4 ();
    param_stream_mux_if #(.NUM_CH(3), .DATA_W(8)) bus3 ();

    param_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    param_stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int d, input int ch, input logic [7:0] data, input logic last);
        sbuf[d][ch][tail[d][ch]] = {last, data};
        tail[d][ch]++;
    endtask

    task automatic expectBeat(input int d, input logic [7:0] data, input logic last);
        if (d == 0) exp_q4.push_back({last, data});
        else        exp_q3.push_back({last, data});
    endtask

    function automatic bit buffersEmpty(input int d);
        bit e;
        e = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (head[d][c] != tail[d][c]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic waitDrain(input int d);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (d == 0) done = (exp_q4.size() == 0) && !bus4.busy && !bus4.out_valid && buffersEmpty(0);
            else        done = (exp_q3.size() == 0) && !bus3.busy && !bus3.out_valid && buffersEmpty(1);
        end
        checkOutput(d == 0 ? "drain4" : "drain3", 32'(done), 32'd1);
    endtask

    // Producer for the 4-channel instance: presents each channel's buffer head, pops on handshake.
    initial begin : drv4
        logic [3:0] acc;
        acc = '0;
        bus4.in_valid = '0;
        bus4.in_last  = '0;
        bus4.in_data  = '0;
        forever begin
            @(posedge clk);
            for (int c = 0; c < 4; c++) if (acc[c] && head[0][c] < tail[0][c]) head[0][c]++;
            #2;
            for (int c = 0; c < 4; c++) begin
                if (head[0][c] < tail[0][c]) begin
                    bus4.in_valid[c]       = 1'b1;
                    bus4.in_last[c]        = sbuf[0][c][head[0][c]][8];
                    bus4.in_data[c*8 +: 8] = sbuf[0][c][head[0][c]][7:0];
                end else begin
                    bus4.in_valid[c]       = 1'b0;
                    bus4.in_last[c]        = 1'b0;
                    bus4.in_data[c*8 +: 8] = 8'h00;
                end
            end
            @(negedge clk);
            acc = bus4.in_valid & bus4.in_ready;
        end
    end

    initial begin : drv3
        logic [2:0] acc;
        acc = '0;
        bus3.in_valid = '0;
        bus3.in_last  = '0;
        bus3.in_data  = '0;
        forever begin
            @(posedge clk);
            for (int c = 0; c < 3; c++) if (acc[c] && head[1][c] < tail[1][c]) head[1][c]++;
            #2;
            for (int c = 0; c < 3; c++) begin
                if (head[1][c] < tail[1][c]) begin
                    bus3.in_valid[c]       = 1'b1;
                    bus3.in_last[c]        = sbuf[1][c][head[1][c]][8];
                    bus3.in_data[c*8 +: 8] = sbuf[1][c][head[1][c]][7:0];
                end else begin
                    bus3.in_valid[c]       = 1'b0;
                    bus3.in_last[c]        = 1'b0;
                    bus3.in_data[c*8 +: 8] = 8'h00;
                end
            end
            @(negedge clk);
            acc = bus3.in_valid & bus3.in_ready;
        end
    end

    initial begin : mon4
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus4.out_valid && bus4.out_ready) begin
                if (exp_q4.size() == 0) begin
                    check_count++;
                    err_count++;
                    $display("[TB] FAIL mon4 unexpected beat: got %0h expected none at %0t", bus4.out_data, $time);
                end else begin
                    e = exp_q4.pop_front();
                    checkOutput("mon4 data", 32'(bus4.out_data), 32'(e[7:0]));
                    checkOutput("mon4 last", 32'(bus4.out_last), 32'(e[8]));
                end
            end
        end
    end

    initial begin : mon3
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus3.out_valid && bus3.out_ready) begin
                if (exp_q3.size() == 0) begin
                    check_count++;
                    err_count++;
                    $display("[TB] FAIL mon3 unexpected beat: got %0h expected none at %0t", bus3.out_data, $time);
                end else begin
                    e = exp_q3.pop_front();
                    checkOutput("mon3 data", 32'(bus3.out_data), 32'(e[7:0]));
                    checkOutput("mon3 last", 32'(bus3.out_last), 32'(e[8]));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", err_count + 1, check_count + 1);
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1;
        bus4.mode = MODE_MANUAL; bus4.sel = 2'd0; bus4.out_ready = 1'b1;
        bus3.mode = MODE_MANUAL; bus3.sel = 2'd0; bus3.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("rst out_data",  32'(bus4.out_data),  32'd0);
        checkOutput("rst out_last",  32'(bus4.out_last),  32'd0);
        checkOutput("rst grant",     32'(bus4.grant),     32'd0);
        checkOutput("rst busy",      32'(bus4.busy),      32'd0);
        checkOutput("rst in_ready",  32'(bus4.in_ready),  32'd0);
        checkOutput("rst busy3",     32'(bus3.busy),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] manual three-beat packet on ch2");
        @(posedge clk); #1;
        bus4.sel = 2'd2;
        applyStimulus(0, 2, 8'hA1, 1'b0); expectBeat(0, 8'hA1, 1'b0);
        applyStimulus(0, 2, 8'hA2, 1'b0); expectBeat(0, 8'hA2, 1'b0);
        applyStimulus(0, 2, 8'hA3, 1'b1); expectBeat(0, 8'hA3, 1'b1);
        @(negedge clk);
        checkOutput("t1 busy before arb", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        checkOutput("t1 busy",       32'(bus4.busy),      32'd1);
        checkOutput("t1 grant",      32'(bus4.grant),     32'd2);
        checkOutput("t1 lat valid0", 32'(bus4.out_valid), 32'd0);
        checkOutput("t1 in_ready",   32'(bus4.in_ready),  32'b0100);
        @(negedge clk);
        checkOutput("t1 lat valid1", 32'(bus4.out_valid), 32'd1);
        checkOutput("t1 first data", 32'(bus4.out_data),  32'hA1);
        @(negedge clk);
        checkOutput("t1 beat2 valid", 32'(bus4.out_valid), 32'd1);
        @(negedge clk);
        checkOutput("t1 beat3 last", 32'(bus4.out_last), 32'd1);
        checkOutput("t1 idle after last", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        checkOutput("t1 drained", 32'(bus4.out_valid), 32'd0);
        waitDrain(0);

        $display("[TB] round-robin fairness");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus4.mode = MODE_RR;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(0, c, 8'(c * 16 + r), 1'b1);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                expectBeat(0, 8'(c * 16 + r), 1'b1);
            end
        end
        waitDrain(0);
        @(posedge clk); #1;
        applyStimulus(0, 1, 8'h12, 1'b1);
        applyStimulus(0, 3, 8'h32, 1'b1);
        applyStimulus(0, 1, 8'h13, 1'b1);
        applyStimulus(0, 3, 8'h33, 1'b1);
        expectBeat(0, 8'h12, 1'b1);
        expectBeat(0, 8'h32, 1'b1);
        expectBeat(0, 8'h13, 1'b1);
        expectBeat(0, 8'h33, 1'b1);
        waitDrain(0);
        checkOutput("t2 final grant", 32'(bus4.grant), 32'd3);

        $display("[TB] packet lock against sel/mode change");
        @(posedge clk); #1;
        bus4.mode = MODE_MANUAL;
        bus4.sel  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'(8'hC0 + i), i == 3);
            expectBeat(0, 8'(8'hC0 + i), i == 3);
        end
        expectBeat(0, 8'hD0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t3 grant", 32'(bus4.grant), 32'd0);
        checkOutput("t3 busy",  32'(bus4.busy),  32'd1);
        @(posedge clk); #1;
        bus4.sel  = 2'd3;
        bus4.mode = MODE_RR;
        applyStimulus(0, 3, 8'hD0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t3 in_ready locked", 32'(bus4.in_ready), 32'b0001);
            checkOutput("t3 grant held",      32'(bus4.grant),    32'd0);
        end
        @(negedge clk);
        checkOutput("t3 idle after last", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        checkOutput("t3 next grant", 32'(bus4.grant), 32'd3);
        waitDrain(0);

        $display("[TB] backpressure");
        @(posedge clk); #1;
        bus4.mode      = MODE_MANUAL;
        bus4.sel       = 2'd1;
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 8'(8'hB0 + i), i == 3);
            expectBeat(0, 8'(8'hB0 + i), i == 3);
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4 in_ready empty reg", 32'(bus4.in_ready), 32'b0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t4 stall valid",    32'(bus4.out_valid), 32'd1);
            checkOutput("t4 stall data",     32'(bus4.out_data),  32'hB0);
            checkOutput("t4 stall in_ready", 32'(bus4.in_ready),  32'd0);
        end
        @(posedge clk); #1;
        bus4.out_ready = 1'b1;
        waitDrain(0);

        $display("[TB] three-channel boundary");
        @(posedge clk); #1;
        bus3.mode = MODE_MANUAL;
        bus3.sel  = 2'd3;
        applyStimulus(1, 0, 8'h50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t5 no grant busy",  32'(bus3.busy),      32'd0);
            checkOutput("t5 no grant ready", 32'(bus3.in_ready),  32'd0);
            checkOutput("t5 no grant valid", 32'(bus3.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        bus3.mode = MODE_RR;
        applyStimulus(1, 0, 8'h51, 1'b1);
        applyStimulus(1, 2, 8'h62, 1'b1);
        expectBeat(1, 8'h50, 1'b1);
        expectBeat(1, 8'h62, 1'b1);
        expectBeat(1, 8'h51, 1'b1);
        waitDrain(1);
        checkOutput("t5 final grant", 32'(bus3.grant), 32'd0);

        $display("[TB] async reset mid-packet");
        @(posedge clk); #1;
        bus4.mode = MODE_RR;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 2, 8'(8'hE0 + i), i == 3);
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6 grant before rst", 32'(bus4.grant), 32'd2);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("t6 rst out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("t6 rst out_data",  32'(bus4.out_data),  32'd0);
        checkOutput("t6 rst out_last",  32'(bus4.out_last),  32'd0);
        checkOutput("t6 rst busy",      32'(bus4.busy),      32'd0);
        checkOutput("t6 rst grant",     32'(bus4.grant),     32'd0);
        checkOutput("t6 rst in_ready",  32'(bus4.in_ready),  32'd0);
        head[0][2] = tail[0][2];
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 3, 8'h93, 1'b1);
        applyStimulus(0, 1, 8'h91, 1'b1);
        applyStimulus(0, 0, 8'h90, 1'b1);
        expectBeat(0, 8'h90, 1'b1);
        expectBeat(0, 8'h91, 1'b1);
        expectBeat(0, 8'h93, 1'b1);
        waitDrain(0);
        checkOutput("t6 final grant", 32'(bus4.grant), 32'd3);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
